spi_ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port RAM between the SPI slave's command stream (requester A) and a local host command port (requester B). Both requesters issue 10-bit RAM command words (bits [9:8]: 00 write-address, 01 write-data, 10 read-address, 11 read-data, bits [7:0] payload). The arbiter grants the RAM for a whole address/data transaction and routes read data back to the owner. It sits between the SPI slave/host logic and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` pins.

---
 rtl/spi_ram_arbiter_if.sv | 38 +++
 rtl/spi_ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_arbiter_if.sv
// Bundle of both requester ports, the RAM command/response pins and the owner indication.
// The slave modport is the arbiter side; master is the requester/RAM side.
interface spi_ram_arbiter_if;
  logic [9:0] a_din;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_rsp_data;
  logic       a_rsp_valid;
  logic       a_err;

  logic [9:0] b_din;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_rsp_data;
  logic       b_rsp_valid;
  logic       b_err;

  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;

  logic [1:0] owner;

  modport slave (
    input  a_din, a_valid, b_din, b_valid, ram_dout, ram_tx_valid,
    output a_ready, a_rsp_data, a_rsp_valid, a_err,
    output b_ready, b_rsp_data, b_rsp_valid, b_err,
    output ram_din, ram_rx_valid, owner
  );

  modport master (
    output a_din, a_valid, b_din, b_valid, ram_dout, ram_tx_valid,
    input  a_ready, a_rsp_data, a_rsp_valid, a_err,
    input  b_ready, b_rsp_data, b_rsp_valid, b_err,
    input  ram_din, ram_rx_valid, owner
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Two-requester RAM arbiter that locks the RAM for a whole address/data transaction.
// Define ARB_TIMEOUT_EN to add a watchdog that releases a stalled lock after TIMEOUT idle cycles.
module spi_ram_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic            clk,
  input logic            rst,
  spi_ram_arbiter_if.slave bus
);

  if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_cfg
    $error("spi_ram_arbiter: TIMEOUT must lie in 1 .. 2**CNT_W-1");
  end

  typedef enum logic [1:0] {IDLE, LOCK_WR, LOCK_RD, WAIT_RD} state_t;

  state_t     state, state_nxt;
  logic       own_b, own_b_nxt;
  logic       ptr, ptr_nxt;
  logic       grant_a, grant_b;
  logic       accept, acc_b;
  logic [9:0] acc_word;
  logic       fwd, err, err_b, rsp;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

  // In IDLE the round-robin pointer breaks ties; inside a lock only the owner may talk.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state)
      IDLE: begin
        grant_a = bus.a_valid & (~bus.b_valid | ~ptr);
        grant_b = bus.b_valid & (~bus.a_valid | ptr);
      end
      LOCK_WR, LOCK_RD: begin
        grant_a = ~own_b;
        grant_b = own_b;
      end
      default: ;
    endcase
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign acc_b       = bus.b_valid & grant_b;
  assign accept      = (bus.a_valid & grant_a) | acc_b;
  assign acc_word    = acc_b ? bus.b_din : bus.a_din;
  assign bus.owner   = (state == IDLE) ? 2'b00 : (own_b ? 2'b10 : 2'b01);

  always_comb begin
    state_nxt = state;
    own_b_nxt = own_b;
    ptr_nxt   = ptr;
    fwd       = 1'b0;
    err       = 1'b0;
    err_b     = acc_b;
    rsp       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (acc_word[9:8])
            2'b00: begin fwd = 1'b1; state_nxt = LOCK_WR; own_b_nxt = acc_b; end
            2'b10: begin fwd = 1'b1; state_nxt = LOCK_RD; own_b_nxt = acc_b; end
            default: err = 1'b1;
          endcase
        end
      end
      LOCK_WR: begin
        if (accept) begin
          unique case (acc_word[9:8])
            2'b01: begin fwd = 1'b1; state_nxt = IDLE; ptr_nxt = ~own_b; end
            2'b00: fwd = 1'b1;
            default: err = 1'b1;
          endcase
        end
      end
      LOCK_RD: begin
        if (accept) begin
          unique case (acc_word[9:8])
            2'b11: begin fwd = 1'b1; state_nxt = WAIT_RD; end
            2'b10: fwd = 1'b1;
            default: err = 1'b1;
          endcase
        end
      end
      WAIT_RD: begin
        if (bus.ram_tx_valid) begin
          rsp       = 1'b1;
          state_nxt = IDLE;
          ptr_nxt   = ~own_b;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    // The watchdog only overrides cycles in which nothing happened, so it never races a real transition.
    cnt_nxt = '0;
    if (state != IDLE && !(accept || bus.ram_tx_valid)) begin
      if (cnt == CNT_W'(TIMEOUT - 1)) begin
        state_nxt = IDLE;
        ptr_nxt   = ~own_b;
        err       = 1'b1;
        err_b     = own_b;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      own_b           <= 1'b0;
      ptr             <= 1'b0;
      bus.ram_din     <= '0;
      bus.ram_rx_valid <= 1'b0;
      bus.a_rsp_data  <= '0;
      bus.a_rsp_valid <= 1'b0;
      bus.a_err       <= 1'b0;
      bus.b_rsp_data  <= '0;
      bus.b_rsp_valid <= 1'b0;
      bus.b_err       <= 1'b0;
    end else begin
      state           <= state_nxt;
      own_b           <= own_b_nxt;
      ptr             <= ptr_nxt;
      bus.ram_rx_valid <= fwd;
      if (fwd) bus.ram_din <= acc_word;
      bus.a_rsp_valid <= rsp & ~own_b;
      bus.b_rsp_valid <= rsp & own_b;
      if (rsp & ~own_b) bus.a_rsp_data <= bus.ram_dout;
      if (rsp & own_b)  bus.b_rsp_data <= bus.ram_dout;
      bus.a_err       <= err & ~err_b;
      bus.b_err       <= err & err_b;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter; the timeout scenario follows ARB_TIMEOUT_EN.
// Inputs change #1 after a rising edge; registered outputs are sampled at that same point.
module tb_spi_ram_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  spi_ram_arbiter_if bus ();

  spi_ram_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    total++; if (bus.ram_din !== 10'h000) begin bad++; $display("[TB] FAIL rst_ram_din: got %h expected %h", bus.ram_din, 10'h000); end
    total++; if (bus.ram_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rx_valid: got %b expected 0", bus.ram_rx_valid); end
    total++; if (bus.owner !== 2'b00) begin bad++; $display("[TB] FAIL rst_owner: got %b expected 00", bus.owner); end
    total++; if ({bus.a_rsp_valid, bus.b_rsp_valid, bus.a_err, bus.b_err} !== 4'b0000) begin bad++; $display("[TB] FAIL rst_strobes: got %b expected 0000", {bus.a_rsp_valid, bus.b_rsp_valid, bus.a_err, bus.b_err}); end
    total++; if ({bus.a_rsp_data, bus.b_rsp_data} !== 16'h0000) begin bad++; $display("[TB] FAIL rst_rsp_data: got %h expected 0000", {bus.a_rsp_data, bus.b_rsp_data}); end
    total++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin bad++; $display("[TB] FAIL rst_ready: got %b expected 00", {bus.a_ready, bus.b_ready}); end
  endtask

  task automatic test_write_b();
    step();
    bus.b_valid = 1'b1;
    bus.b_din   = 10'h03C;
    #1;
    total++; if ({bus.a_ready, bus.b_ready} !== 2'b01) begin bad++; $display("[TB] FAIL wr_grant: got %b expected 01", {bus.a_ready, bus.b_ready}); end
    step();
    total++; if (bus.ram_din !== 10'h03C || bus.ram_rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL wr_addr_fwd: got %h/%b expected 03c/1", bus.ram_din, bus.ram_rx_valid); end
    total++; if (bus.owner !== 2'b10) begin bad++; $display("[TB] FAIL wr_owner_b: got %b expected 10", bus.owner); end
    bus.b_din   = 10'h1A5;
    bus.a_valid = 1'b1;
    bus.a_din   = 10'h000;
    #1;
    total++; if (bus.a_ready !== 1'b0) begin bad++; $display("[TB] FAIL wr_a_stalled: got %b expected 0", bus.a_ready); end
    step();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    total++; if (bus.ram_din !== 10'h1A5 || bus.ram_rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL wr_data_fwd: got %h/%b expected 1a5/1", bus.ram_din, bus.ram_rx_valid); end
    total++; if (bus.owner !== 2'b00) begin bad++; $display("[TB] FAIL wr_owner_release: got %b expected 00", bus.owner); end
    step();
    total++; if (bus.ram_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_strobe_single: got %b expected 0", bus.ram_rx_valid); end
  endtask

  task automatic test_read_a();
    bus.a_valid = 1'b1;
    bus.a_din   = 10'h23C;
    step();
    total++; if (bus.ram_din !== 10'h23C || bus.owner !== 2'b01) begin bad++; $display("[TB] FAIL rd_addr: got %h/%b expected 23c/01", bus.ram_din, bus.owner); end
    bus.a_din = 10'h300;
    step();
    bus.a_valid = 1'b0;
    total++; if (bus.ram_din !== 10'h300 || bus.ram_rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL rd_data_cmd: got %h/%b expected 300/1", bus.ram_din, bus.ram_rx_valid); end
    total++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin bad++; $display("[TB] FAIL rd_wait_ready: got %b expected 00", {bus.a_ready, bus.b_ready}); end
    bus.ram_dout     = 8'hA5;
    bus.ram_tx_valid = 1'b1;
    step();
    bus.ram_tx_valid = 1'b0;
    total++; if (bus.a_rsp_valid !== 1'b1 || bus.a_rsp_data !== 8'hA5) begin bad++; $display("[TB] FAIL rd_rsp: got %b/%h expected 1/a5", bus.a_rsp_valid, bus.a_rsp_data); end
    total++; if (bus.b_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_b_rsp_quiet: got %b expected 0", bus.b_rsp_valid); end
    total++; if (bus.owner !== 2'b00) begin bad++; $display("[TB] FAIL rd_owner_release: got %b expected 00", bus.owner); end
    step();
    total++; if (bus.a_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_rsp_single: got %b expected 0", bus.a_rsp_valid); end
  endtask

  task automatic test_contention();
    logic [9:0] a_addr, b_addr, win_data;
    logic       exp_b;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_b  = i[0];
      a_addr = 10'h010 + 10'(i);
      b_addr = 10'h020 + 10'(i);
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      bus.a_din   = a_addr;
      bus.b_din   = b_addr;
      #1;
      total++; if ({bus.a_ready, bus.b_ready} !== {~exp_b, exp_b}) begin bad++; $display("[TB] FAIL arb_grant_%0d: got %b expected %b", i, {bus.a_ready, bus.b_ready}, {~exp_b, exp_b}); end
      step();
      total++; if (bus.owner !== (exp_b ? 2'b10 : 2'b01) || bus.ram_din !== (exp_b ? b_addr : a_addr)) begin bad++; $display("[TB] FAIL arb_lock_%0d: got %b/%h expected %b/%h", i, bus.owner, bus.ram_din, (exp_b ? 2'b10 : 2'b01), (exp_b ? b_addr : a_addr)); end
      win_data = 10'h100 | 10'(8'hA0 + 8'(i));
      if (exp_b) bus.b_din = win_data;
      else       bus.a_din = win_data;
      #1;
      total++; if ((exp_b ? bus.a_ready : bus.b_ready) !== 1'b0) begin bad++; $display("[TB] FAIL arb_loser_stall_%0d: got %b expected 0", i, (exp_b ? bus.a_ready : bus.b_ready)); end
      step();
      total++; if (bus.ram_din !== win_data || bus.owner !== 2'b00) begin bad++; $display("[TB] FAIL arb_release_%0d: got %h/%b expected %h/00", i, bus.ram_din, bus.owner, win_data); end
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    step();
  endtask

  task automatic test_protocol_error();
    bus.b_valid = 1'b1;
    bus.b_din   = 10'h1FF;
    #1;
    total++; if (bus.b_ready !== 1'b1) begin bad++; $display("[TB] FAIL perr_b_ready: got %b expected 1", bus.b_ready); end
    step();
    bus.b_valid = 1'b0;
    total++; if (bus.b_err !== 1'b1 || bus.ram_rx_valid !== 1'b0 || bus.owner !== 2'b00) begin bad++; $display("[TB] FAIL perr_idle: got err=%b rx=%b owner=%b expected 1/0/00", bus.b_err, bus.ram_rx_valid, bus.owner); end
    step();
    total++; if (bus.b_err !== 1'b0) begin bad++; $display("[TB] FAIL perr_single: got %b expected 0", bus.b_err); end
    bus.a_valid = 1'b1;
    bus.a_din   = 10'h010;
    step();
    total++; if (bus.ram_din !== 10'h010 || bus.owner !== 2'b01 || bus.a_err !== 1'b0) begin bad++; $display("[TB] FAIL perr_lock: got %h/%b/%b expected 010/01/0", bus.ram_din, bus.owner, bus.a_err); end
    bus.a_din = 10'h300;
    step();
    bus.a_valid = 1'b0;
    total++; if (bus.a_err !== 1'b1 || bus.ram_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL perr_locked_err: got err=%b rx=%b expected 1/0", bus.a_err, bus.ram_rx_valid); end
    total++; if (bus.owner !== 2'b01) begin bad++; $display("[TB] FAIL perr_lock_held: got %b expected 01", bus.owner); end
    step();
    total++; if (bus.a_err !== 1'b0) begin bad++; $display("[TB] FAIL perr_locked_single: got %b expected 0", bus.a_err); end
    bus.a_valid = 1'b1;
    bus.a_din   = 10'h155;
    step();
    bus.a_valid = 1'b0;
    total++; if (bus.ram_din !== 10'h155 || bus.owner !== 2'b00) begin bad++; $display("[TB] FAIL perr_finish: got %h/%b expected 155/00", bus.ram_din, bus.owner); end
    step();
  endtask

  task automatic test_timeout();
    bus.a_valid = 1'b1;
    bus.a_din   = 10'h201;
    step();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1;
    bus.b_din   = 10'h077;
    #1;
    total++; if (bus.owner !== 2'b01 || bus.b_ready !== 1'b0) begin bad++; $display("[TB] FAIL to_lock: got %b/%b expected 01/0", bus.owner, bus.b_ready); end
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (bus.a_err !== 1'b0 || bus.owner !== 2'b01) begin bad++; $display("[TB] FAIL to_early_%0d: got err=%b owner=%b expected 0/01", k, bus.a_err, bus.owner); end
    end
    step();
    total++; if (bus.a_err !== 1'b1 || bus.owner !== 2'b00) begin bad++; $display("[TB] FAIL to_fire: got err=%b owner=%b expected 1/00", bus.a_err, bus.owner); end
    total++; if (bus.b_ready !== 1'b1) begin bad++; $display("[TB] FAIL to_b_ready: got %b expected 1", bus.b_ready); end
    step();
    total++; if (bus.owner !== 2'b10 || bus.ram_din !== 10'h077 || bus.a_err !== 1'b0) begin bad++; $display("[TB] FAIL to_b_granted: got %b/%h/%b expected 10/077/0", bus.owner, bus.ram_din, bus.a_err); end
`else
    repeat (10) step();
    total++; if (bus.owner !== 2'b01 || bus.a_err !== 1'b0 || bus.b_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_lock: got %b/%b/%b expected 01/0/0", bus.owner, bus.a_err, bus.b_ready); end
    bus.a_valid = 1'b1;
    bus.a_din   = 10'h300;
    step();
    bus.a_valid      = 1'b0;
    bus.ram_dout     = 8'h5A;
    bus.ram_tx_valid = 1'b1;
    step();
    bus.ram_tx_valid = 1'b0;
    #1;
    total++; if (bus.a_rsp_valid !== 1'b1 || bus.a_rsp_data !== 8'h5A) begin bad++; $display("[TB] FAIL hold_rsp: got %b/%h expected 1/5a", bus.a_rsp_valid, bus.a_rsp_data); end
    total++; if (bus.b_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_same_cycle_grant: got %b expected 1", bus.b_ready); end
    step();
    total++; if (bus.owner !== 2'b10 || bus.ram_din !== 10'h077) begin bad++; $display("[TB] FAIL hold_b_granted: got %b/%h expected 10/077", bus.owner, bus.ram_din); end
`endif
    bus.b_din = 10'h100;
    step();
    bus.b_valid = 1'b0;
    total++; if (bus.owner !== 2'b00 || bus.ram_din !== 10'h100) begin bad++; $display("[TB] FAIL to_b_finish: got %b/%h expected 00/100", bus.owner, bus.ram_din); end
    step();
  endtask

  task automatic test_reset_mid_read();
    bus.a_valid = 1'b1;
    bus.a_din   = 10'h242;
    step();
    bus.a_din = 10'h300;
    step();
    bus.a_valid = 1'b0;
    total++; if (bus.owner !== 2'b01) begin bad++; $display("[TB] FAIL mrst_locked: got %b expected 01", bus.owner); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.owner !== 2'b00 || bus.ram_din !== 10'h000 || bus.ram_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_outputs: got %b/%h/%b expected 00/000/0", bus.owner, bus.ram_din, bus.ram_rx_valid); end
    total++; if (bus.a_rsp_data !== 8'h00 || bus.a_rsp_valid !== 1'b0 || bus.a_err !== 1'b0) begin bad++; $display("[TB] FAIL mrst_rsp: got %h/%b/%b expected 00/0/0", bus.a_rsp_data, bus.a_rsp_valid, bus.a_err); end
    bus.ram_dout     = 8'hEE;
    bus.ram_tx_valid = 1'b1;
    step();
    bus.ram_tx_valid = 1'b0;
    total++; if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00 || bus.a_rsp_data !== 8'h00) begin bad++; $display("[TB] FAIL mrst_late_tx: got %b/%h expected 00/00", {bus.a_rsp_valid, bus.b_rsp_valid}, bus.a_rsp_data); end
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst              = 1'b1;
    bus.a_din        = '0;
    bus.a_valid      = 1'b0;
    bus.b_din        = '0;
    bus.b_valid      = 1'b0;
    bus.ram_dout     = '0;
    bus.ram_tx_valid = 1'b0;
    test_reset();
    test_write_b();
    test_read_a();
    test_contention();
    test_protocol_error();
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
